// File: rtl/branch_comp.sv
// Branch comparator for the RV32I datapath.
// Reports registered equality and less-than flags for rs1/rs2 to branch
// control. BrUn selects unsigned (1) or two's-complement signed (0) ordering.
module branch_comp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] operand_0,
  input  logic [WIDTH-1:0] operand_1,
  input  logic             BrUn,
  output logic             BrEq,
  output logic             BrLT
);

  // Zero-extended difference: the top bit is the unsigned borrow and bit
  // WIDTH-1 is the sign of the WIDTH-bit difference.
  logic [WIDTH:0] diff;
  logic           signsDiffer;
  logic           ltUnsigned;
  logic           ltSigned;
  logic           eqNext;
  logic           ltNext;

  // Combinational compare feeding the two flag flops.
  always_comb begin
    diff        = {1'b0, operand_0} - {1'b0, operand_1};
    signsDiffer = operand_0[WIDTH-1] ^ operand_1[WIDTH-1];
    ltUnsigned  = diff[WIDTH];
    // With differing signs the negative operand is the smaller one; with equal
    // signs the subtraction cannot overflow, so its sign bit is exact.
    ltSigned    = signsDiffer ? operand_0[WIDTH-1] : diff[WIDTH-1];
    eqNext      = ~|(operand_0 ^ operand_1);
    ltNext      = BrUn ? ltUnsigned : ltSigned;
  end

  // Register both flags; synchronous active-low reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      BrEq <= 1'b0;
      BrLT <= 1'b0;
    end else begin
      BrEq <= eqNext;
      BrLT <= ltNext;
    end
  end

endmodule

// File: tb/tb_branch_comp.sv
// Self-checking bench for branch_comp: expected flags are pushed to a queue
// when each stimulus is driven and popped when the registered result appears.
module tb_branch_comp;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] operand_0;
  logic [WIDTH-1:0] operand_1;
  logic             BrUn;
  logic             BrEq;
  logic             BrLT;

  logic [1:0] expQ[$];
  int         errCount = 0;
  int         checkCount = 0;

  branch_comp #(
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .operand_0(operand_0),
    .operand_1(operand_1),
    .BrUn     (BrUn),
    .BrEq     (BrEq),
    .BrLT     (BrLT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single compare point for every check in the bench.
  task automatic checkVal(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got {BrEq,BrLT}=%b expected %b", tag, got, exp);
    end
  endtask

  // Reference model written from the behavioural definition of the flags.
  function automatic logic [1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic un, input logic rstN);
    logic eq;
    logic lt;
    if (!rstN) return 2'b00;
    eq = (a == b);
    lt = un ? (a < b) : ($signed(a) < $signed(b));
    return {eq, lt};
  endfunction

  // Drive one vector, push its expectation, then pop and compare after the edge.
  task automatic applyVec(input string tag, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic un, input logic rstN);
    logic [1:0] exp;
    operand_0 = a;
    operand_1 = b;
    BrUn      = un;
    rst_n     = rstN;
    expQ.push_back(model(a, b, un, rstN));
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checkVal({tag, "_queue_empty"}, 2'bxx, 2'b00);
    end else begin
      exp = expQ.pop_front();
      checkVal(tag, {BrEq, BrLT}, exp);
      // Flags must hold their registered value between edges.
      #3;
      checkVal({tag, "_hold"}, {BrEq, BrLT}, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    operand_0 = '0;
    operand_1 = '0;
    BrUn      = 1'b0;
    @(negedge clk);

    // Reset held with equal operands keeps both flags low.
    applyVec("rst_hold0", 32'd100, 32'd100, 1'b0, 1'b0);
    applyVec("rst_hold1", 32'd100, 32'd100, 1'b1, 1'b0);
    checkVal("rst_const", {BrEq, BrLT}, 2'b00);

    // First comparison after release appears one clock later.
    applyVec("rst_release", 32'd100, 32'd100, 1'b0, 1'b1);
    checkVal("rst_release_eq", {BrEq, BrLT}, 2'b10);

    applyVec("eq_signed", 32'd100, 32'd100, 1'b0, 1'b1);
    applyVec("eq_unsigned", 32'd100, 32'd100, 1'b1, 1'b1);
    applyVec("slt_signed", 32'hFFFF_FFF6, 32'd5, 1'b0, 1'b1);
    applyVec("slt_unsigned", 32'hFFFF_FFF6, 32'd5, 1'b1, 1'b1);
    applyVec("big_unsigned", 32'hFFFF_FFF0, 32'd5, 1'b1, 1'b1);
    applyVec("big_signed", 32'hFFFF_FFF0, 32'd5, 1'b0, 1'b1);
    applyVec("gt_signed", 32'd200, 32'd100, 1'b0, 1'b1);
    applyVec("gt_swapped", 32'd100, 32'd200, 1'b0, 1'b1);
    applyVec("gt_swapped_u", 32'd100, 32'd200, 1'b1, 1'b1);
    applyVec("min_max_s", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);
    applyVec("min_max_u", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1);
    applyVec("max_min_s", 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);
    applyVec("neg1_zero_s", 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    applyVec("neg1_zero_u", 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1);
    applyVec("zero_neg1_u", 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b1);
    applyVec("zero_zero_u", 32'd0, 32'd0, 1'b1, 1'b1);
    applyVec("zero_zero_s", 32'd0, 32'd0, 1'b0, 1'b1);
    applyVec("ones_ones_s", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    applyVec("lsb_diff_u", 32'd6, 32'd7, 1'b1, 1'b1);
    applyVec("msb_diff_s", 32'h8000_0001, 32'h0000_0001, 1'b0, 1'b1);

    // Reset asserted mid-stream clears flags on that edge.
    applyVec("slt_pre_rst", 32'hFFFF_FFF6, 32'd5, 1'b0, 1'b1);
    applyVec("rst_midstream", 32'hFFFF_FFF6, 32'd5, 1'b0, 1'b0);
    applyVec("post_rst", 32'd3, 32'd9, 1'b1, 1'b1);

    // Random sweep, with occasional shared values to hit equality.
    for (int i = 0; i < 200; i++) begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      a = $urandom();
      b = ($urandom_range(0, 7) == 0) ? a : WIDTH'($urandom());
      applyVec("random", a, b, 1'($urandom_range(0, 1)), 1'b1);
    end

    checkVal("queue_drained", 2'(expQ.size()), 2'b00);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
